stack_frame_builder: RTL
========================

Name: stack_frame_builder

Overview:
- Upstream producer of the 64-bit frame consumed by the LED matrix row/column scan controller.
- Implements the "stacker" game as one FSM. It replaces the chain of per-row block-shift stages.
- A block bounces across the active row on a timer tick. A stop-button press locks it onto the row below, trimmed to the overlap; the row pointer then advances.
- Reports win, lose and done for the status LEDs.

Parameters:
- ROWS, 8, number of matrix rows (fixed to 8 in this revision).
- COLS, 8, row width in bits.
- INIT_MASK, 8'h07, starting block pattern for row 0.
- SYNC_STAGES, 2, flop stages on the stop_btn synchronizer.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- start_sw  in  1  level; high = play, low = abort/return to IDLE
- stop_btn  in  1  raw pushbutton, asynchronous; rising edge = lock block
- step_tick  in  1  one-clk pulse from the timer chain; moves the block one column
- frame  out  64  row r occupies frame[63-8r -: 8]; row 0 = bits 63:56 (bottom)
- frame_upd  out  1  one-clk pulse whenever frame changes
- win  out  1  level; all ROWS rows locked
- lose  out  1  level; locked overlap was zero
- done  out  1  win | lose
- row_idx  out  3  current active row

Behaviour:
- Reset (rst==0 on a clk edge):
  - frame=0, frame_upd=0, win=0, lose=0, done=0, row_idx=0.
  - state=IDLE; synchronizer flops cleared.
  - All outputs are registered.
- States: IDLE, PLAY, WIN, LOSE.
- IDLE:
  - frame=0.
  - When start_sw==1: next state PLAY; load moving mask=INIT_MASK and dir=left (toward MSB); row_idx=0.
  - frame shows row 0 = INIT_MASK the following cycle, with frame_upd pulsed.
- PLAY, step_tick (no stop edge):
  - If dir=left and mask[COLS-1]==1: set dir=right, mask>>=1.
  - Else if dir=right and mask[0]==1: set dir=left, mask<<=1.
  - Otherwise shift in the current dir.
  - The block never leaves the row; width is preserved.
- PLAY, stop edge:
  - The stop edge is the rising edge of the synchronized stop_btn.
  - below = all-ones for row 0, else the locked mask of row_idx-1.
  - ov = mask & below.
  - If ov==0: go to LOSE. The active row keeps mask as displayed; it is not cleared.
  - Else: lock row_idx = ov.
    - If row_idx==ROWS-1: go to WIN.
    - Else: row_idx+1; the new moving mask = ov, same dir.
- Stop edge and step_tick in the same cycle: the stop wins. It is evaluated on the pre-move mask; the tick is discarded.
- Latency: stop_btn rising in the cycle-n sample means edge detected at n+SYNC_STAGES and frame updated at n+SYNC_STAGES+1. step_tick at cycle n means frame updated at n+1.
- frame composition:
  - Locked rows 0..row_idx-1.
  - Active row = moving mask (in PLAY) or final mask (in WIN/LOSE).
  - Rows above row_idx = 0.
- WIN/LOSE:
  - The frame freezes; step_tick and stop edges are ignored.
  - win or lose holds high, and done=1.
  - start_sw==0 returns to IDLE: clears frame and flags, pulses frame_upd.
- start_sw falling while in PLAY: go to IDLE next cycle, same clearing.
- A button held high produces exactly one stop edge. Bounce is filtered only by the synchronizer; debouncing is upstream.
- Reset mid-game: immediate return to the reset values, regardless of state.

Decomposition:
- Shared package stack_pkg holds:
  - state enum {IDLE, PLAY, WIN, LOSE}
  - ROWS, COLS
  - DIR_LEFT/DIR_RIGHT constants
  - a frame row-slice helper function
- Sub-module btn_edge_sync: SYNC_STAGES-flop synchronizer plus rising-edge detect; clk/rst ports, active-low synchronous reset.

Test Plan:
- Reset then start_sw=1, no ticks -> frame=64'h0700_0000_0000_0000, row_idx=0, frame_upd pulses once.
- 5 step_ticks -> row0 mask 0xE0. A 6th tick -> 0x70 (bounce). Tick at 0x07 after returning right -> 0x0E (bounce at LSB).
- Stop with row0=0x07, then 1 tick, then stop on row1=0x0E -> row1 locked 0x06, row2 moving 0x06, frame=64'h0706_0600_0000_0000.
- Row0 locked 0x07; move row1 to 0x70; stop -> lose=1, done=1, frame=64'h0770_0000_0000_0000. Further ticks/stops leave the frame unchanged. start_sw=0 -> frame=0, lose=0.
- Stop 8 times with no ticks -> win=1, done=1, frame=64'h0707_0707_0707_0707, row_idx=7.
- Stop edge and step_tick in the same cycle at row0=0x07 -> row0 locked 0x07 (not 0x0E). rst=0 mid-game -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and frame helpers for the stacker frame builder.
package stack_pkg;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int FRAME_W = ROWS * COLS;
    localparam int ROW_W   = $clog2(ROWS);

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_e;

    // Row r lives at frame[FRAME_W-1-COLS*r -: COLS]; row 0 is the MSB byte.
    function automatic logic [COLS-1:0] getRow(input logic [FRAME_W-1:0] f,
                                              input logic [ROW_W-1:0] r);
        getRow = '0;
        for (int i = 0; i < ROWS; i++)
            if (r == ROW_W'(i)) getRow = f[FRAME_W-1-COLS*i -: COLS];
    endfunction

    function automatic logic [FRAME_W-1:0] setRow(input logic [FRAME_W-1:0] f,
                                                 input logic [ROW_W-1:0] r,
                                                 input logic [COLS-1:0] v);
        setRow = f;
        for (int i = 0; i < ROWS; i++)
            if (r == ROW_W'(i)) setRow[FRAME_W-1-COLS*i -: COLS] = v;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Multi-flop synchronizer for the raw stop button with a rising-edge strobe.
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   lastQ;

    always_ff @(posedge clk) begin
        if (!rst) begin
            syncQ <= '0;
            lastQ <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], btn};
            lastQ <= syncQ[SYNC_STAGES-1];
        end
    end

    // A held button yields a single-cycle strobe.
    assign rise = syncQ[SYNC_STAGES-1] & ~lastQ;

endmodule

// File: rtl/stack_frame_builder.sv
// Stacker game FSM: bounces a block on the active row, locks the overlap on
// a stop edge, and publishes the 64-bit frame plus win/lose status.
module stack_frame_builder
    import stack_pkg::*;
#(
    parameter logic [COLS-1:0] INIT_MASK   = 8'h07,
    parameter int              SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_sw,
    input  logic               stop_btn,
    input  logic               step_tick,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_upd,
    output logic               win,
    output logic               lose,
    output logic               done,
    output logic [ROW_W-1:0]   row_idx
);

    state_e          state;
    logic [COLS-1:0] mask;
    logic            dir;
    logic            stopEdge;
    logic [COLS-1:0] below;
    logic [COLS-1:0] ov;
    logic [COLS-1:0] tickMask;
    logic            tickDir;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
        .clk  (clk),
        .rst  (rst),
        .btn  (stop_btn),
        .rise (stopEdge)
    );

    assign below = (row_idx == '0) ? '1 : getRow(frame, row_idx - ROW_W'(1));
    assign ov    = mask & below;

    // Bounce off either wall by reversing and stepping back inside the row.
    always_comb begin
        tickDir  = dir;
        tickMask = mask;
        if (dir == DIR_LEFT) begin
            if (mask[COLS-1]) begin
                tickDir  = DIR_RIGHT;
                tickMask = mask >> 1;
            end else begin
                tickMask = mask << 1;
            end
        end else begin
            if (mask[0]) begin
                tickDir  = DIR_LEFT;
                tickMask = mask << 1;
            end else begin
                tickMask = mask >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mask      <= '0;
            dir       <= DIR_LEFT;
            frame     <= '0;
            frame_upd <= 1'b0;
            win       <= 1'b0;
            lose      <= 1'b0;
            done      <= 1'b0;
            row_idx   <= '0;
        end else begin
            frame_upd <= 1'b0;
            if (state != IDLE && !start_sw) begin
                state     <= IDLE;
                frame     <= '0;
                frame_upd <= 1'b1;
                win       <= 1'b0;
                lose      <= 1'b0;
                done      <= 1'b0;
                row_idx   <= '0;
            end else begin
                case (state)
                    IDLE: if (start_sw) begin
                        state     <= PLAY;
                        mask      <= INIT_MASK;
                        dir       <= DIR_LEFT;
                        row_idx   <= '0;
                        frame     <= setRow('0, '0, INIT_MASK);
                        frame_upd <= 1'b1;
                    end
                    PLAY: begin
                        // Stop is judged on the pre-move mask; a coincident tick is dropped.
                        if (stopEdge) begin
                            if (ov == '0) begin
                                state <= LOSE;
                                lose  <= 1'b1;
                                done  <= 1'b1;
                            end else if (row_idx == ROW_W'(ROWS-1)) begin
                                state     <= WIN;
                                win       <= 1'b1;
                                done      <= 1'b1;
                                mask      <= ov;
                                frame     <= setRow(frame, row_idx, ov);
                                frame_upd <= (ov != mask);
                            end else begin
                                row_idx   <= row_idx + ROW_W'(1);
                                mask      <= ov;
                                frame     <= setRow(setRow(frame, row_idx, ov),
                                                    row_idx + ROW_W'(1), ov);
                                frame_upd <= 1'b1;
                            end
                        end else if (step_tick) begin
                            mask      <= tickMask;
                            dir       <= tickDir;
                            frame     <= setRow(frame, row_idx, tickMask);
                            frame_upd <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
